// File: rtl/mult_div_unit_pkg.sv
// mult_div_unit_pkg
//   Definitions shared by the multiply/divide unit and the control unit:
//   unit state encoding and the R-type funct codes that launch it.
package mult_div_unit_pkg;

    localparam int MDU_DATA_WIDTH = 32;
    localparam int MDU_CNT_WIDTH  = 6;

    // R-type funct field values that start the unit
    localparam logic [5:0] FUNCT_MULT = 6'b011000;
    localparam logic [5:0] FUNCT_DIV  = 6'b011010;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MULT    = 3'd1,
        ST_DIV     = 3'd2,
        ST_DIV_FIX = 3'd3,
        ST_DONE    = 3'd4
    } mdu_state_t;

endpackage

// File: rtl/mult_div_unit_booth_step.sv
// mult_div_unit_booth_step
//   One radix-2 Booth iteration, purely combinational.
//   prod_in  : {acc, Q, q_-1} product register (2*DATA_WIDTH+1 bits)
//   mcand    : multiplicand
//   prod_out : register after the add/sub and one arithmetic right shift
module mult_div_unit_booth_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [2*DATA_WIDTH:0] prod_in,
    input  logic [DATA_WIDTH-1:0] mcand,
    output logic [2*DATA_WIDTH:0] prod_out
);
    localparam int W = DATA_WIDTH;

    logic [W:0] acc_ext;
    logic [W:0] m_ext;
    logic [W:0] sum;

    // Accumulator is sign-extended one bit so that acc +/- M never
    // overflows (e.g. -2^(W-1) * -2^(W-1)); the shift drops that bit again.
    assign acc_ext = {prod_in[2*W], prod_in[2*W:W+1]};
    assign m_ext   = {mcand[W-1], mcand};

    always_comb begin
        sum = acc_ext;
        case (prod_in[1:0])
            2'b01:   sum = acc_ext + m_ext;
            2'b10:   sum = acc_ext - m_ext;
            default: sum = acc_ext;
        endcase
    end

    assign prod_out = {sum, prod_in[W:1]};

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Sequential signed multiply / divide unit writing HI/LO.
//   Clock            rising-edge clock
//   Reset            asynchronous active-low reset
//   Start_Mult/Div   one-cycle start pulses (mult wins if both high)
//   A, B             operands, sampled with the start pulse
//   HI_Out, LO_Out   mult: product high/low; div: remainder/quotient
//   Busy             operation in progress
//   Done             one-cycle completion pulse
//   Div_Zero         pulses with Done when the divisor was zero
module mult_div_unit
    import mult_div_unit_pkg::*;
#(
    parameter int DATA_WIDTH = MDU_DATA_WIDTH,
    parameter int CNT_WIDTH  = MDU_CNT_WIDTH
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start_Mult,
    input  logic                  Start_Div,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic [DATA_WIDTH-1:0] HI_Out,
    output logic [DATA_WIDTH-1:0] LO_Out,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Div_Zero
);
    localparam int W = DATA_WIDTH;

    mdu_state_t           state, next_state;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 last;
    logic                 accept;

    logic [2*W:0]         prod;
    logic [2*W:0]         prod_nxt;
    logic [W-1:0]         mcand;

    logic [W-1:0]         rem;
    logic [W-1:0]         quo;
    logic [W-1:0]         dvs;
    logic                 a_neg;
    logic                 b_neg;
    logic                 dz;

    logic [W:0]           shifted;
    logic [W:0]           diff;

    assign last   = (cnt == CNT_WIDTH'(W - 1));
    assign accept = (state == ST_IDLE) || (state == ST_DONE);

    mult_div_unit_booth_step #(.DATA_WIDTH(W)) u_booth (
        .prod_in  (prod),
        .mcand    (mcand),
        .prod_out (prod_nxt)
    );

    // Restoring divider step: bring down the next dividend bit, trial subtract
    assign shifted = {rem, quo[W-1]};
    assign diff    = shifted - {1'b0, dvs};

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (Start_Mult)     next_state = ST_MULT;
                else if (Start_Div) next_state = ST_DIV;
                else                next_state = ST_IDLE;
            end
            ST_MULT:    next_state = last ? ST_DONE : ST_MULT;
            // A zero divisor spends one cycle here and leaves without iterating
            ST_DIV:     next_state = dz ? ST_DONE : (last ? ST_DIV_FIX : ST_DIV);
            ST_DIV_FIX: next_state = ST_DONE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cnt    <= '0;
            prod   <= '0;
            mcand  <= '0;
            rem    <= '0;
            quo    <= '0;
            dvs    <= '0;
            a_neg  <= 1'b0;
            b_neg  <= 1'b0;
            dz     <= 1'b0;
            HI_Out <= '0;
            LO_Out <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (Start_Mult) begin
                        prod  <= {{W{1'b0}}, B, 1'b0};
                        mcand <= A;
                        cnt   <= '0;
                        dz    <= 1'b0;
                    end else if (Start_Div) begin
                        rem   <= '0;
                        quo   <= A[W-1] ? -A : A;
                        dvs   <= B[W-1] ? -B : B;
                        a_neg <= A[W-1];
                        b_neg <= B[W-1];
                        dz    <= (B == '0);
                        cnt   <= '0;
                    end
                end
                ST_MULT: begin
                    prod <= prod_nxt;
                    cnt  <= cnt + 1'b1;
                    if (last) {HI_Out, LO_Out} <= prod_nxt[2*W:1];
                end
                ST_DIV: begin
                    if (!dz) begin
                        cnt <= cnt + 1'b1;
                        if (diff[W]) begin
                            rem <= shifted[W-1:0];
                            quo <= {quo[W-2:0], 1'b0};
                        end else begin
                            rem <= diff[W-1:0];
                            quo <= {quo[W-2:0], 1'b1};
                        end
                    end
                end
                ST_DIV_FIX: begin
                    // Truncating division: quotient sign from sign(A)^sign(B),
                    // remainder follows the dividend
                    LO_Out <= (a_neg ^ b_neg) ? -quo : quo;
                    HI_Out <= a_neg ? -rem : rem;
                end
                default: ;
            endcase
        end
    end

    assign Busy     = (state == ST_MULT) || (state == ST_DIV) || (state == ST_DIV_FIX);
    assign Done     = (state == ST_DONE);
    assign Div_Zero = (state == ST_DONE) && dz;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit
//   Randomized and directed checks of mult_div_unit against a plain
//   arithmetic reference (64-bit signed multiply, truncating divide).
module tb_mult_div_unit;
    logic        Clock;
    logic        Reset;
    logic        Start_Mult;
    logic        Start_Div;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] HI_Out;
    logic [31:0] LO_Out;
    logic        Busy;
    logic        Done;
    logic        Div_Zero;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] ref_hi = '0;
    logic [31:0] ref_lo = '0;

    mult_div_unit dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Start_Mult (Start_Mult),
        .Start_Div  (Start_Div),
        .A          (A),
        .B          (B),
        .HI_Out     (HI_Out),
        .LO_Out     (LO_Out),
        .Busy       (Busy),
        .Done       (Done),
        .Div_Zero   (Div_Zero)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue a start, optionally pulse Start_Div while busy, then wait for Done
    // and compare with the arithmetic reference.
    task automatic run_op(input string tag, input bit sm, input bit sd,
                          input logic [31:0] a, input logic [31:0] b, input bit poke);
        longint p, q, r, sa, sb;
        logic [63:0] pv;
        logic [31:0] e_hi, e_lo;
        bit e_dz;
        int e_lat, cyc, idle_gap, dones;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        e_dz = 1'b0;
        if (sm) begin
            p = sa * sb;
            pv = p;
            e_hi = pv[63:32];
            e_lo = pv[31:0];
            e_lat = 32;
        end else if (b == 0) begin
            e_hi = ref_hi;
            e_lo = ref_lo;
            e_dz = 1'b1;
            e_lat = 1;
        end else begin
            q = sa / sb;
            r = sa % sb;
            pv = q;
            e_lo = pv[31:0];
            pv = r;
            e_hi = pv[31:0];
            e_lat = 33;
        end

        @(negedge Clock);
        Start_Mult = sm;
        Start_Div  = sd;
        A = a;
        B = b;
        @(posedge Clock);
        #1;
        Start_Mult = 1'b0;
        Start_Div  = 1'b0;
        A = $urandom;
        B = $urandom;
        cyc = 0;
        idle_gap = 0;
        dones = 0;
        while (!Done && cyc < 100) begin
            if (!Busy) idle_gap++;
            if (poke && cyc == 5) begin
                Start_Div = 1'b1;
                Start_Mult = 1'b1;
            end else begin
                Start_Div = 1'b0;
                Start_Mult = 1'b0;
            end
            @(posedge Clock);
            #1;
            cyc++;
        end
        Start_Div = 1'b0;
        Start_Mult = 1'b0;
        check({tag, " latency"}, 64'(cyc), 64'(e_lat));
        check({tag, " busy_gap"}, 64'(idle_gap), 64'd0);
        check({tag, " hi"}, 64'(HI_Out), 64'(e_hi));
        check({tag, " lo"}, 64'(LO_Out), 64'(e_lo));
        check({tag, " div_zero"}, 64'(Div_Zero), 64'(e_dz));
        check({tag, " busy_at_done"}, 64'(Busy), 64'd0);
        ref_hi = e_hi;
        ref_lo = e_lo;
        @(posedge Clock);
        #1;
        if (Done) dones++;
        if (Div_Zero) dones++;
        check({tag, " pulse_end"}, 64'(dones), 64'd0);
        check({tag, " hold_hi"}, 64'(HI_Out), 64'(e_hi));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'(int'($urandom_range(40)) - 20);
            3: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        Reset = 1'b0;
        Start_Mult = 1'b0;
        Start_Div = 1'b0;
        A = '0;
        B = '0;
        #1;
        check("reset hi", 64'(HI_Out), 64'd0);
        check("reset lo", 64'(LO_Out), 64'd0);
        check("reset flags", 64'({Busy, Done, Div_Zero}), 64'd0);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;

        run_op("mul 7*-3", 1, 0, 32'd7, 32'hFFFF_FFFD, 0);
        run_op("mul min*min", 1, 0, 32'h8000_0000, 32'h8000_0000, 0);
        run_op("div -7/2", 0, 1, 32'hFFFF_FFF9, 32'd2, 0);
        run_op("div 100/7", 0, 1, 32'd100, 32'd7, 0);
        run_op("div 5/0", 0, 1, 32'd5, 32'd0, 0);
        run_op("div min/-1", 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op("both starts", 1, 1, 32'd1234, 32'hFFFF_FF00, 0);
        run_op("start mid mult", 1, 0, 32'h0001_0001, 32'd99, 1);
        run_op("start mid div", 0, 1, 32'h8765_4321, 32'd13, 1);

        // Reset in the middle of a multiply
        @(negedge Clock);
        Start_Mult = 1'b1;
        A = 32'd12345;
        B = 32'd678;
        @(posedge Clock);
        #1;
        Start_Mult = 1'b0;
        repeat (10) @(posedge Clock);
        #1;
        Reset = 1'b0;
        #1;
        check("midreset hi", 64'(HI_Out), 64'd0);
        check("midreset lo", 64'(LO_Out), 64'd0);
        check("midreset flags", 64'({Busy, Done, Div_Zero}), 64'd0);
        repeat (3) @(posedge Clock);
        #1;
        check("midreset no done", 64'({Busy, Done}), 64'd0);
        @(negedge Clock);
        Reset = 1'b1;
        ref_hi = '0;
        ref_lo = '0;
        run_op("mul after reset", 1, 0, 32'hFFFF_FC18, 32'd1000, 0);

        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            bit m;
            a = pick();
            b = pick();
            if ($urandom_range(7) == 0) b = '0;
            m = $urandom_range(1) == 1;
            run_op(m ? "rand mul" : "rand div", m, !m, a, b, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end, %0d checks so far", n_checks);
        $fatal(1);
    end

endmodule
